// File: rtl/pll_pkg.sv
// Shared state encoding and 16 MHz default timing for the PLL reset sequencer.
package pll_pkg;

   typedef logic [2:0] pll_state_t;

   localparam pll_state_t StHold     = 3'd0;
   localparam pll_state_t StWaitLock = 3'd1;
   localparam pll_state_t StSettle   = 3'd2;
   localparam pll_state_t StRun      = 3'd3;
   localparam pll_state_t StFault    = 3'd4;

   localparam int unsigned LOCK_SYNC_STAGES = 2;

   localparam int unsigned DEF_RESET_CYCLES  = 16;
   localparam int unsigned DEF_LOCK_TIMEOUT  = 1600;  // 100 us at 16 MHz
   localparam int unsigned DEF_STABLE_CYCLES = 256;
   localparam int unsigned DEF_MAX_RETRIES   = 3;
   localparam int unsigned DEF_CNT_W         = 16;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop bit synchronizer with asynchronous active-low clear.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         q      <= 1'b0;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL start-up / recovery sequencer in the reference clock domain.
// Optional bypass fallback in FAULT: define PLL_BYPASS_FALLBACK_EN.
module pll_reset_sequencer
   import pll_pkg::*;
#(
   parameter int unsigned RESET_CYCLES  = DEF_RESET_CYCLES,
   parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
   parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int unsigned MAX_RETRIES   = DEF_MAX_RETRIES,
   parameter int unsigned CNT_W         = DEF_CNT_W
) (
   input  logic       clk_in,
   input  logic       rst_n,
   input  logic       pll_lock,
   output logic       pll_resetb,
   output logic       pll_bypass,
   output logic       sys_reset,
   output logic [2:0] state_o,
   output logic [1:0] retry_cnt,
   output logic [7:0] lock_loss_cnt,
   output logic       fault
);

   localparam logic [CNT_W-1:0] HoldLast    = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] StableLast  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [1:0]       RetryMax    = 2'(MAX_RETRIES);

   logic             lock_s;
   pll_state_t       state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic [1:0]       retry_q, retry_d;
   logic [7:0]       loss_q, loss_d;
   logic             sys_reset_q, sys_reset_d;
   logic             resetb_q, fault_q;

   sync_2ff u_lock_sync (
      .clk   (clk_in),
      .rst_n (rst_n),
      .d     (pll_lock),
      .q     (lock_s)
   );

   always_comb begin
      state_d = state_q;
      timer_d = timer_q + CNT_W'(1);
      retry_d = retry_q;
      loss_d  = loss_q;
      unique case (state_q)
         StHold: begin
            if (timer_q == HoldLast) begin
               state_d = StWaitLock;
               timer_d = '0;
            end
         end
         StWaitLock: begin
            // Lock on the timeout cycle wins over the retry.
            if (lock_s) begin
               state_d = StSettle;
               timer_d = '0;
            end else if (timer_q == TimeoutLast) begin
               timer_d = '0;
               if (retry_q < RetryMax) begin
                  retry_d = retry_q + 2'd1;
                  state_d = StHold;
               end else begin
                  state_d = StFault;
               end
            end
         end
         StSettle: begin
            if (!lock_s) begin
               state_d = StWaitLock;
               timer_d = '0;
            end else if (timer_q == StableLast) begin
               state_d = StRun;
               timer_d = '0;
               retry_d = '0;
            end
         end
         StRun: begin
            timer_d = '0;
            if (!lock_s) begin
               state_d = StHold;
               if (loss_q != 8'hff) loss_d = loss_q + 8'd1;
            end
         end
         StFault: begin
            // Saturate so the bypass release point stays stable forever.
            if (timer_q == HoldLast) timer_d = timer_q;
         end
         default: begin
            state_d = StHold;
            timer_d = '0;
         end
      endcase
   end

   always_comb begin
      sys_reset_d = !(state_q == StRun && lock_s);
`ifdef PLL_BYPASS_FALLBACK_EN
      if (state_q == StFault && timer_q == HoldLast) sys_reset_d = 1'b0;
`endif
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StHold;
         timer_q     <= '0;
         retry_q     <= '0;
         loss_q      <= '0;
         sys_reset_q <= 1'b1;
         resetb_q    <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         retry_q     <= retry_d;
         loss_q      <= loss_d;
         sys_reset_q <= sys_reset_d;
         resetb_q    <= !(state_d == StHold || state_d == StFault);
         fault_q     <= (state_d == StFault);
      end
   end

`ifdef PLL_BYPASS_FALLBACK_EN
   logic bypass_q;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) bypass_q <= 1'b0;
      else        bypass_q <= (state_d == StFault);
   end

   assign pll_bypass = bypass_q;
`else
   assign pll_bypass = 1'b0;
`endif

   assign pll_resetb    = resetb_q;
   assign sys_reset     = sys_reset_q;
   assign state_o       = state_q;
   assign retry_cnt     = retry_q;
   assign lock_loss_cnt = loss_q;
   assign fault         = fault_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: directed test-plan scenarios plus random lock
// patterns, all compared against a phase/elapsed-time reference model.
module tb_pll_reset_sequencer;

   localparam int RESET_CYCLES  = 16;
   localparam int LOCK_TIMEOUT  = 1600;
   localparam int STABLE_CYCLES = 256;
   localparam int MAX_RETRIES   = 3;

   localparam int PhHold = 0, PhWait = 1, PhSettle = 2, PhRun = 3, PhFault = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pll_lock = 1'b0;
   logic       pll_resetb, pll_bypass, sys_reset, fault;
   logic [2:0] state_o;
   logic [1:0] retry_cnt;
   logic [7:0] lock_loss_cnt;

   int checks = 0;
   int errors = 0;
   int cycle  = 0;

   // Reference model: phase, cycles elapsed in phase, counters, lock delay line.
   int m_phase, m_elapsed, m_retries, m_losses;
   bit m_sysrst;
   bit m_pipe [2];

   always #31 clk = ~clk;

   pll_reset_sequencer #(
      .RESET_CYCLES  (RESET_CYCLES),
      .LOCK_TIMEOUT  (LOCK_TIMEOUT),
      .STABLE_CYCLES (STABLE_CYCLES),
      .MAX_RETRIES   (MAX_RETRIES),
      .CNT_W         (16)
   ) dut (
      .clk_in        (clk),
      .rst_n         (rst_n),
      .pll_lock      (pll_lock),
      .pll_resetb    (pll_resetb),
      .pll_bypass    (pll_bypass),
      .sys_reset     (sys_reset),
      .state_o       (state_o),
      .retry_cnt     (retry_cnt),
      .lock_loss_cnt (lock_loss_cnt),
      .fault         (fault)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h exp 0x%0h (cycle %0d)", tag, got, exp, cycle);
      end
   endtask

   function automatic logic [16:0] dut_vec();
      return {state_o, retry_cnt, lock_loss_cnt, pll_resetb, pll_bypass, sys_reset, fault};
   endfunction

   function automatic logic [16:0] model_vec();
      logic resetb_e, bypass_e, fault_e;
      fault_e  = (m_phase == PhFault);
      resetb_e = !(m_phase == PhHold || m_phase == PhFault);
`ifdef PLL_BYPASS_FALLBACK_EN
      bypass_e = fault_e;
`else
      bypass_e = 1'b0;
`endif
      return {3'(m_phase), 2'(m_retries), 8'(m_losses), resetb_e, bypass_e, m_sysrst, fault_e};
   endfunction

   task automatic model_reset();
      m_phase   = PhHold;
      m_elapsed = 0;
      m_retries = 0;
      m_losses  = 0;
      m_sysrst  = 1'b1;
      m_pipe[0] = 1'b0;
      m_pipe[1] = 1'b0;
   endtask

   task automatic model_step(input bit lock_in);
      bit ls;
      int nxt;
      ls  = m_pipe[1];
      nxt = m_phase;
      m_elapsed++;
      case (m_phase)
         PhHold:   if (m_elapsed == RESET_CYCLES) nxt = PhWait;
         PhWait: begin
            if (ls) nxt = PhSettle;
            else if (m_elapsed == LOCK_TIMEOUT) begin
               if (m_retries < MAX_RETRIES) begin
                  m_retries++;
                  nxt = PhHold;
               end else begin
                  nxt = PhFault;
               end
            end
         end
         PhSettle: begin
            if (!ls) nxt = PhWait;
            else if (m_elapsed == STABLE_CYCLES) begin
               nxt = PhRun;
               m_retries = 0;
            end
         end
         PhRun: begin
            if (!ls) begin
               nxt = PhHold;
               if (m_losses < 255) m_losses++;
            end
         end
         default: ;
      endcase
      m_sysrst = !(m_phase == PhRun && ls);
`ifdef PLL_BYPASS_FALLBACK_EN
      if (m_phase == PhFault && m_elapsed >= RESET_CYCLES) m_sysrst = 1'b0;
`endif
      if (nxt != m_phase) m_elapsed = 0;
      m_phase   = nxt;
      m_pipe[1] = m_pipe[0];
      m_pipe[0] = lock_in;
   endtask

   // One clock: compare at negedge, drive lock, advance DUT and model together.
   task automatic tick(input bit lock);
      @(negedge clk);
      check_eq("outs", 32'(dut_vec()), 32'(model_vec()));
      rst_n    = 1'b1;
      pll_lock = lock;
      @(posedge clk);
      #1;
      model_step(lock);
      cycle++;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n    = 1'b0;
      pll_lock = 1'b0;
      #1;
      check_eq("rst_sys_reset", sys_reset, 1);
      check_eq("rst_pll_resetb", pll_resetb, 0);
      check_eq("rst_state", state_o, 0);
      check_eq("rst_counters", {retry_cnt, lock_loss_cnt}, 0);
      check_eq("rst_fault", {fault, pll_bypass}, 0);
      model_reset();
      @(posedge clk);
      #1;
      cycle = 0;
   endtask

   initial begin
      int n, t0, seen, rise_at, low_cnt;
      logic [1:0] prev;

      // Nominal start: lock 50 cycles after PLL reset release.
      apply_reset();
      repeat (RESET_CYCLES + 50) tick(0);
      n = 0;
      while (sys_reset && n < 600) begin tick(1); n++; end
      check_eq($sformatf("nom_fall@%0d", cycle), 32'(cycle >= 324 && cycle <= 326), 1);
      check_eq("nom_retry", retry_cnt, 0);
      repeat (10) tick(1);

      // Lock never arrives: three retries, then FAULT.
      apply_reset();
      seen = 0;
      prev = retry_cnt;
      n = 0;
      while (!fault && n < 7000) begin
         tick(0);
         n++;
         if (retry_cnt != prev) seen = seen * 10 + int'(retry_cnt);
         prev = retry_cnt;
      end
      check_eq($sformatf("fault_at@%0d", cycle), 32'(cycle >= 6463 && cycle <= 6466), 1);
      check_eq("retry_seq", seen, 123);
`ifdef PLL_BYPASS_FALLBACK_EN
      repeat (RESET_CYCLES) tick(0);
      check_eq("fb_sys_reset", sys_reset, 0);
      check_eq("fb_bypass", pll_bypass, 1);
      repeat (20) tick(1);
`else
      repeat (40) tick(1);
      check_eq("fault_sys_reset", sys_reset, 1);
      check_eq("fault_bypass", pll_bypass, 0);
`endif
      check_eq("fault_held", fault, 1);

      // Glitchy lock during SETTLE.
      apply_reset();
      repeat (20) tick(0);
      repeat (100) tick(1);
      repeat (3) tick(0);
      t0 = cycle;
      n = 0;
      while (sys_reset && n < 600) begin tick(1); n++; end
      check_eq($sformatf("glitch_fall+%0d", cycle - t0),
               32'(cycle - t0 >= 256 && cycle - t0 <= 262), 1);
      check_eq("glitch_retry", retry_cnt, 0);

      // Loss of lock in RUN.
      repeat (5) tick(1);
      rise_at = -1;
      low_cnt = 0;
      for (int k = 0; k < 5; k++) begin
         tick(0);
         if (sys_reset && rise_at < 0) rise_at = k + 1;
         if (!pll_resetb) low_cnt++;
      end
      check_eq($sformatf("loss_rise@%0d", rise_at), 32'(rise_at >= 1 && rise_at <= 3), 1);
      check_eq("loss_cnt", lock_loss_cnt, 1);
      n = 0;
      while (sys_reset && n < 800) begin
         tick(1);
         n++;
         if (!pll_resetb) low_cnt++;
      end
      check_eq("loss_resetb_low", low_cnt, RESET_CYCLES);
      check_eq("loss_rerun", state_o, 3);

      // Async reset in the middle of SETTLE.
      apply_reset();
      n = 0;
      while (state_o != 3'd2 && n < 100) begin tick(1); n++; end
      check_eq("settle_reached", state_o, 2);
      repeat (100) tick(1);
      apply_reset();
      n = 0;
      while (sys_reset && n < 600) begin tick(1); n++; end
      check_eq("restart_run", {state_o, sys_reset}, {3'd3, 1'b0});

      // Random lock patterns, with occasional long drops and async resets.
      for (int ep = 0; ep < 8; ep++) begin
         apply_reset();
         n = 0;
         while (n < 2500) begin
            int unsigned r, len;
            bit lvl;
            r = $urandom_range(0, 99);
            if (r < 60) begin
               lvl = 1'b1;
               len = $urandom_range(1, 400);
            end else if (r < 92) begin
               lvl = 1'b0;
               len = $urandom_range(1, 12);
            end else if (r < 97) begin
               lvl = 1'b0;
               len = $urandom_range(1500, 1700);
            end else begin
               lvl = 1'b0;
               len = 0;
               apply_reset();
            end
            for (int k = 0; k < int'(len); k++) begin
               tick(lvl);
               n++;
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Controls the PLL start-up and recovery sequence and runs in the 16 MHz reference clock domain.
- Drives the PLL RESETB and BYPASS pins and watches the asynchronous LOCK pin.
- Releases the system reset only after lock has been stable for a set time.
- Retries on lock timeout, re-sequences on loss of lock, and stops in FAULT after too many failed retries.

Parameters:
- RESET_CYCLES, 16, cycles RESETB is held low in HOLD (must be ≥1).
- LOCK_TIMEOUT, 1600, cycles to wait for synced lock before a retry (100 us at 16 MHz).
- STABLE_CYCLES, 256, consecutive synced-lock cycles required before reset release.
- MAX_RETRIES, 3, failed lock attempts tolerated before FAULT.
- CNT_W, 16, timer width; must hold max(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).

Ports:
- clk_in  input  1  16 MHz reference clock; the only clock.
- rst_n  input  1  Asynchronous active-low reset.
- pll_lock  input  1  PLL LOCK pin; asynchronous, synchronized internally.
- pll_resetb  output  1  To PLL RESETB; 0 holds the PLL in reset.
- pll_bypass  output  1  To PLL BYPASS.
- sys_reset  output  1  High-level system reset; downstream logic synchronizes it into its own domain.
- state_o  output  3  Current state encoding, for debug.
- retry_cnt  output  2  Failed attempts since the last success (saturating).
- lock_loss_cnt  output  8  Loss-of-lock events seen in RUN (saturating at 255).
- fault  output  1  1 while in FAULT.

Behaviour:
- Lock synchronizer: 2-FF chain, lock_s = stage 2. All decisions use lock_s only.
- Reset (rst_n=0, asynchronous):
  - state=HOLD, timer=0.
  - Outputs: pll_resetb=0, pll_bypass=0, sys_reset=1, retry_cnt=0, lock_loss_cnt=0, fault=0.
  - Sync FFs cleared.
- State encoding: HOLD=0, WAIT_LOCK=1, SETTLE=2, RUN=3, FAULT=4.
- HOLD:
  - pll_resetb=0, sys_reset=1.
  - timer counts 0..RESET_CYCLES-1, then goes to WAIT_LOCK with timer cleared.
- WAIT_LOCK:
  - pll_resetb=1, sys_reset=1.
  - lock_s=1 → SETTLE, timer=0.
  - Else, if timer==LOCK_TIMEOUT-1 → failed attempt:
    - retry_cnt < MAX_RETRIES: retry_cnt++, go to HOLD.
    - Otherwise: go to FAULT.
  - Lock arriving on the timeout cycle takes priority; go to SETTLE.
- SETTLE:
  - sys_reset=1.
  - lock_s=0 on any cycle → back to WAIT_LOCK, timer=0. The WAIT_LOCK timeout restarts; this is not counted as a retry.
  - lock_s=1 for STABLE_CYCLES consecutive cycles (timer reaches STABLE_CYCLES-1) → RUN, and retry_cnt is cleared.
- RUN:
  - sys_reset=0, registered, so it deasserts 1 cycle after the state enters RUN.
  - lock_s=0 → sys_reset=1 on the next edge, lock_loss_cnt++ (saturating), go to HOLD.
  - retry_cnt is not modified on loss of lock.
- FAULT:
  - Terminal state; pll_resetb=0, sys_reset=1, fault=1.
  - Left only by rst_n.
- Latency figures:
  - Raw pll_lock edge to lock_s: 2 cycles.
  - Minimum rst_n deassert to sys_reset=0: RESET_CYCLES + 2 + STABLE_CYCLES + 1 cycles, assuming the PLL locks immediately.
- Invariants:
  - sys_reset=1 in every state except RUN.
  - pll_resetb=0 only in HOLD and FAULT.
  - Timer is cleared on every state transition.

Optional Feature:
- Macro: PLL_BYPASS_FALLBACK_EN.
- Defined:
  - On entry to FAULT: pll_bypass=1, pll_resetb=0, and after RESET_CYCLES sys_reset=0. The system then runs on the 16 MHz reference passed through BYPASS.
  - fault stays 1.
  - Lock is ignored in FAULT.
- Undefined:
  - pll_bypass is tied to 0.
  - FAULT holds sys_reset=1 permanently.

Decomposition:
- Shared package pll_pkg holds:
  - the state enum (3-bit, values as listed above);
  - LOCK_SYNC_STAGES=2;
  - default timing constants for a 16 MHz reference.
- One natural sub-module, sync_2ff, a generic bit synchronizer with async active-low clear; it is reused elsewhere.

Test Plan:
- Nominal start: pll_lock rises 50 cycles after reset release and stays high → sys_reset falls at cycle 16+50+2+256+1 (±1); retry_cnt=0.
- Timeout retry: pll_lock held 0 → HOLD/WAIT_LOCK repeats 3 times with retry_cnt 1,2,3, then FAULT. fault=1 at cycle 4×(16+1600)+1 approx; sys_reset stays 1.
- Glitchy lock: lock high 100 cycles, low 3 cycles, then high → SETTLE aborts, retry_cnt unchanged; sys_reset falls 256+ cycles after the final rise.
- Loss in RUN: from RUN, drop pll_lock for 5 cycles → sys_reset=1 within 3 cycles of the drop, lock_loss_cnt=1, pll_resetb=0 for 16 cycles, then re-lock and RUN again.
- Async reset mid-SETTLE: assert rst_n=0 at SETTLE timer=100 → immediately sys_reset=1, pll_resetb=0, all counters 0; the sequence restarts cleanly.
- With PLL_BYPASS_FALLBACK_EN: lock never asserts → after FAULT entry pll_bypass=1, and sys_reset=0 16 cycles later; fault=1.
